// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// default operand width.
package div_pkg;

    localparam int unsigned DivSizeDefault = 32;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StStep = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned SIZE = DivSizeDefault
) (
    input  logic [SIZE-1:0] r_i,
    input  logic            d_msb_i,
    input  logic [SIZE-1:0] dv_i,
    output logic [SIZE-1:0] r_next_o,
    output logic            q_bit_o
);

    // SIZE+1 bits so a divisor with its MSB set cannot overflow the trial value.
    logic [SIZE:0] trial;
    logic [SIZE:0] dv_ext;

    always_comb begin
        trial    = {r_i, d_msb_i};
        dv_ext   = {1'b0, dv_i};
        q_bit_o  = (trial >= dv_ext);
        r_next_o = q_bit_o ? SIZE'(trial - dv_ext) : trial[SIZE-1:0];
    end

endmodule

// File: rtl/seq_div_ctrl.sv
// Sequential restoring-division controller: one quotient bit per clock, with
// quotient bits appended into an external left-shift SFR via clr/left/incr.
module seq_div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned SIZE = DivSizeDefault
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            q_clr,
    output logic            q_left,
    output logic            q_incr,
    output logic [SIZE-1:0] remainder,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero
);

    localparam int unsigned     CntW    = $clog2(SIZE);
    localparam logic [CntW-1:0] CntLast = CntW'(SIZE - 1);

    div_state_e      state_q;
    logic [SIZE-1:0] r_q;
    logic [SIZE-1:0] d_q;
    logic [SIZE-1:0] dv_q;
    logic [CntW-1:0] cnt_q;
    logic            pend_q;
    logic [SIZE-1:0] rem_q;
    logic            dbz_q;
    logic            done_q;
    logic            busy_q;

    logic [SIZE-1:0] step_r;
    logic            step_bit;

    div_step #(
        .SIZE(SIZE)
    ) u_div_step (
        .r_i     (r_q),
        .d_msb_i (d_q[SIZE-1]),
        .dv_i    (dv_q),
        .r_next_o(step_r),
        .q_bit_o (step_bit)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            r_q     <= '0;
            d_q     <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        d_q     <= dividend;
                        dv_q    <= divisor;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    r_q    <= '0;
                    pend_q <= 1'b0;
                    cnt_q  <= '0;
                    if (dv_q == '0) begin
                        rem_q   <= d_q;
                        dbz_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        dbz_q   <= 1'b0;
                        state_q <= StStep;
                    end
                end
                StStep: begin
                    d_q    <= d_q << 1;
                    r_q    <= step_r;
                    pend_q <= step_bit;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    // Last quotient bit is appended by q_incr this cycle, without a shift.
                    rem_q   <= r_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // SFR strobes are combinational so quotient bits reach Q without extra latency.
    always_comb begin
        q_clr  = clr | (state_q == StLoad);
        q_left = (state_q == StStep);
        q_incr = pend_q & ((state_q == StStep) | (state_q == StFix));
    end

    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Randomized and directed bench for seq_div_ctrl driving a behavioural quotient
// SFR; results are compared against plain integer division.
module tb_seq_div_ctrl;

    localparam int unsigned SIZE = 8;

    logic            clk = 1'b0;
    logic            clr;
    logic            start;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic            q_clr;
    logic            q_left;
    logic            q_incr;
    logic [SIZE-1:0] remainder;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [SIZE-1:0] sfr_q;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    seq_div_ctrl #(
        .SIZE(SIZE)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .q_clr      (q_clr),
        .q_left     (q_left),
        .q_incr     (q_incr),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    // Quotient SFR: incr is applied before the shift when both strobes are high.
    always @(posedge clk) begin
        if (q_clr) begin
            sfr_q <= '0;
        end else if (q_left) begin
            sfr_q <= (sfr_q + SIZE'(q_incr)) << 1;
        end else begin
            sfr_q <= sfr_q + SIZE'(q_incr);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input bit spam);
        logic [SIZE-1:0] exp_q;
        logic [SIZE-1:0] exp_r;
        int              exp_lat;
        int              cyc;
        int              lefts;
        int              incrs;
        exp_q   = (b == 0) ? '0 : a / b;
        exp_r   = (b == 0) ? a : a % b;
        exp_lat = (b == 0) ? 1 : SIZE + 2;

        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Operands must have been captured; scramble them to prove it.
        dividend = SIZE'($urandom);
        divisor  = SIZE'($urandom);
        cyc   = 0;
        lefts = 0;
        incrs = 0;
        while (!done && cyc < 4 * SIZE) begin
            lefts += int'(q_left);
            incrs += int'(q_incr);
            if (spam && busy && cyc[0]) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check_eq("done_seen", done, 1'b1);
        check_eq("latency", cyc, exp_lat);
        check_eq("left_cycles", lefts, (b == 0) ? 0 : SIZE);
        check_eq("incr_cycles", incrs, $countones(exp_q));
        check_eq("quotient", sfr_q, exp_q);
        check_eq("remainder", remainder, exp_r);
        check_eq("div_by_zero", div_by_zero, (b == 0));
        check_eq("busy_at_done", busy, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_pulse", done, 1'b0);
        check_eq("idle_after", busy, 1'b0);
        check_eq("quotient_hold", sfr_q, exp_q);
    endtask

    task automatic run_abort(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_busy_before", busy, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_q", sfr_q, 0);
        check_eq("abort_left", q_left, 1'b0);
        check_eq("abort_qclr", q_clr, 1'b1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_eq("abort_qclr_rel", q_clr, 1'b0);
        @(posedge clk);
        #1;
        check_eq("abort_idle", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_rem", remainder, 0);
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_rem", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 1'b0);
        check_eq("rst_qclr", q_clr, 1'b1);
        check_eq("rst_q", sfr_q, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_eq("rst_qclr_rel", q_clr, 1'b0);
        check_eq("rst_left", q_left, 1'b0);

        run_div(8'd200, 8'd7, 1'b0);
        run_div(8'd255, 8'd1, 1'b0);
        run_div(8'd5, 8'd9, 1'b0);
        run_div(8'd37, 8'd0, 1'b0);
        run_div(8'd40, 8'd8, 1'b0);
        run_div(8'd255, 8'd128, 1'b0);
        run_div(8'd100, 8'd3, 1'b1);
        run_abort(8'd100, 8'd3);
        run_div(8'd100, 8'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [SIZE-1:0] a;
            logic [SIZE-1:0] b;
            int unsigned     sel;
            a   = SIZE'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) b = SIZE'($urandom) | 8'h80;
            else b = SIZE'($urandom);
            run_div(a, b, (sel == 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
